ar_access_arbiter: RTL

Sequences the 12-bit address register (AR) and shares it between the two address sources in the processor: instruction fetch (PC path) and data access (bus path). Takes level requests from both sources, grants one with round-robin priority, drives the AR load strobes (`write_en`, `PC_en`), then holds the memory enable for a fixed number of wait cycles. Finishes each transaction with a one-cycle done pulse to the granted requester. Sits between the control unit and the AR/memory pair.

---
 rtl/proc_pkg.sv | 29 ++
 rtl/ar_access_arbiter_if.sv | 24 ++
 rtl/wait_counter.sv | 29 ++
 rtl/ar_access_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings and limits for the processor's multi-cycle control blocks.
package proc_pkg;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_LOAD   = 2'd1;
  localparam logic [1:0] STATE_ACCESS = 2'd2;
  localparam logic [1:0] STATE_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = STATE_IDLE,
    LOAD   = STATE_LOAD,
    ACCESS = STATE_ACCESS,
    DONE   = STATE_DONE
  } state_e;

  localparam logic GRANT_DATA  = 1'b0;
  localparam logic GRANT_FETCH = 1'b1;

  localparam int MEM_WAIT_MAX = 15;
  localparam int CNT_W        = 4;

  // Single requester wins outright; on a tie the side not served last wins.
  function automatic logic pick_grant(input logic fetch, input logic data, input logic last);
    if (fetch && data) return ~last;
    else if (fetch)    return GRANT_FETCH;
    else               return GRANT_DATA;
  endfunction

endpackage

// File: rtl/ar_access_arbiter_if.sv
// Control-unit side of the AR access arbiter: requests in, AR/memory strobes and done pulses out.
interface ar_access_arbiter_if;
  // Requests are levels held until the matching one-cycle done pulse; data_we is sampled at grant.
  logic fetch_req;
  logic data_req;
  logic data_we;
  logic ar_write_en;
  logic ar_pc_en;
  logic mem_rd_en;
  logic mem_wr_en;
  logic fetch_done;
  logic data_done;
  logic busy;

  modport slave (
    input  fetch_req, data_req, data_we,
    output ar_write_en, ar_pc_en, mem_rd_en, mem_wr_en, fetch_done, data_done, busy
  );

  modport master (
    output fetch_req, data_req, data_we,
    input  ar_write_en, ar_pc_en, mem_rd_en, mem_wr_en, fetch_done, data_done, busy
  );
endinterface

// File: rtl/wait_counter.sv
// 4-bit wait counter with synchronous clear/enable; terminal flags count == limit-1.
module wait_counter
  import proc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             terminal_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign terminal_o = (count_q == (limit_i - 1'b1));

endmodule

// File: rtl/ar_access_arbiter.sv
// Round-robin arbiter sharing the address register between fetch and data accesses.
module ar_access_arbiter
  import proc_pkg::*;
#(
  parameter int reg_width = 12,
  parameter int MEM_WAIT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  ar_access_arbiter_if.slave   ar_bus,
  output state_e               dbg_state_o
);

  if (MEM_WAIT < 1 || MEM_WAIT > MEM_WAIT_MAX) begin : g_bad_mem_wait
    $error("ar_access_arbiter: MEM_WAIT out of range 1..15");
  end
  if (reg_width < 1) begin : g_bad_width
    $error("ar_access_arbiter: reg_width must be positive");
  end

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT);

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;  // doubles as the current grantee while busy
  logic   op_we_q, op_we_d;
  logic   cnt_terminal;

  wait_counter u_wait_counter (
    .clk        (clk),
    .rst_i      (reset),
    .clr_i      (state_q == LOAD),
    .en_i       (state_q == ACCESS),
    .limit_i    (WAIT_LIMIT),
    .terminal_o (cnt_terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_DATA;
      op_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_we_q      <= op_we_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_we_d      = op_we_q;
    case (state_q)
      IDLE: begin
        if (ar_bus.fetch_req || ar_bus.data_req) begin
          last_grant_d = pick_grant(ar_bus.fetch_req, ar_bus.data_req, last_grant_q);
          op_we_d      = (last_grant_d == GRANT_DATA) ? ar_bus.data_we : 1'b0;
          state_d      = LOAD;
        end
      end
      LOAD:    state_d = ACCESS;
      ACCESS:  if (cnt_terminal) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore decode: every output depends only on registered state.
  always_comb begin
    ar_bus.ar_write_en = 1'b0;
    ar_bus.ar_pc_en    = 1'b0;
    ar_bus.mem_rd_en   = 1'b0;
    ar_bus.mem_wr_en   = 1'b0;
    ar_bus.fetch_done  = 1'b0;
    ar_bus.data_done   = 1'b0;
    ar_bus.busy        = (state_q != IDLE);
    case (state_q)
      LOAD: begin
        ar_bus.ar_write_en = 1'b1;
        ar_bus.ar_pc_en    = (last_grant_q == GRANT_FETCH);
      end
      ACCESS: begin
        ar_bus.mem_rd_en = ~op_we_q;
        ar_bus.mem_wr_en = op_we_q;
      end
      DONE: begin
        ar_bus.fetch_done = (last_grant_q == GRANT_FETCH);
        ar_bus.data_done  = (last_grant_q == GRANT_DATA);
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule
